jk_decoder: RTL

USB full-speed receive-side line decoder that turns 4x-oversampled dp/dn line states into an unstuffed, NRZI-decoded bit stream. It sits between the bus pins and the packet/PID deframer and is the receive counterpart of the transmit JK encoder. Per packet it locks bit timing to line transitions, validates the SYNC pattern and strips stuffed bits. It reports each payload bit as a one-cycle strobe, then flags packet completion on EOP or an error on a protocol violation.

---
 rtl/jk_decoder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/jk_decoder.sv
// USB full-speed receive decoder: 4x-oversampled dp/dn -> NRZI-decoded, unstuffed payload bits.
// Define JK_DECODER_INPUT_SYNC_EN to put a two-flop synchronizer ahead of the line register.
module jk_decoder (
    input  logic clk48,
    input  logic reset,
    input  logic dp,
    input  logic dn,
    output logic rx_active,
    output logic bit_out,
    output logic bit_valid,
    output logic done,
    output logic error
);
    localparam int unsigned LINE_W  = 2;
    localparam int unsigned PHASE_W = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned EOP_W   = 2;

    localparam logic [LINE_W-1:0] LINE_J   = 2'b10;
    localparam logic [LINE_W-1:0] LINE_K   = 2'b01;
    localparam logic [LINE_W-1:0] LINE_SE0 = 2'b00;
    localparam logic [LINE_W-1:0] LINE_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD,
        ST_EOP,
        ST_COMPLETE,
        ST_ERROR
    } state_e;

    logic [LINE_W-1:0]  line_in;
    logic [LINE_W-1:0]  line_q, line_prev_q, samp_prev_q, samp_prev_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [CNT_W-1:0]   ones_cnt_q, ones_cnt_d;
    logic [CNT_W-1:0]   j_cnt_q, j_cnt_d;
    logic [EOP_W-1:0]   eop_cnt_q, eop_cnt_d;
    logic rx_active_q, rx_active_d;
    logic bit_out_q, bit_out_d;
    logic bit_valid_q, bit_valid_d;
    logic done_q, done_d;
    logic error_q, error_d;
    logic edge_c, sample_c, one_c, go_err;
    logic [LINE_W-1:0] sync_exp_c;

`ifdef JK_DECODER_INPUT_SYNC_EN
    logic [LINE_W-1:0] meta1_q, meta2_q;

    // Metastability synchronizer for pins that are asynchronous to clk48.
    always_ff @(posedge clk48) begin
        if (!reset) begin
            meta1_q <= LINE_J;
            meta2_q <= LINE_J;
        end else begin
            meta1_q <= {dp, dn};
            meta2_q <= meta1_q;
        end
    end
    assign line_in = meta2_q;
`else
    assign line_in = {dp, dn};
`endif

    // A transition landing on phase 2 still samples the bit that just ended (line_prev),
    // so an early edge costs no bit; without an edge line_prev equals line_q.
    assign edge_c     = (line_q != line_prev_q);
    assign sample_c   = (phase_q == PHASE_W'(2));
    assign one_c      = (line_prev_q == samp_prev_q);
    assign sync_exp_c = (sync_cnt_q[0] && (sync_cnt_q != CNT_W'(7))) ? LINE_J : LINE_K;

    always_comb begin
        state_d     = state_q;
        phase_d     = edge_c ? PHASE_W'(0) : phase_q + PHASE_W'(1);
        samp_prev_d = sample_c ? line_prev_q : samp_prev_q;
        sync_cnt_d  = sync_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        j_cnt_d     = j_cnt_q;
        eop_cnt_d   = eop_cnt_q;
        rx_active_d = rx_active_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        go_err      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_c && (line_prev_q == LINE_K)) begin
                    state_d    = ST_SYNC;
                    sync_cnt_d = CNT_W'(1);
                    ones_cnt_d = CNT_W'(0);
                end
            end
            ST_SYNC: begin
                if (sample_c) begin
                    if (line_prev_q != sync_exp_c) begin
                        state_d = ST_IDLE;
                    end else if (sync_cnt_q == CNT_W'(7)) begin
                        state_d     = ST_PAYLOAD;
                        rx_active_d = 1'b1;
                        ones_cnt_d  = CNT_W'(1);
                    end else begin
                        sync_cnt_d = sync_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (sample_c) begin
                    if (line_prev_q == LINE_SE0) begin
                        state_d   = ST_EOP;
                        eop_cnt_d = EOP_W'(1);
                    end else if (line_prev_q == LINE_SE1) begin
                        go_err = 1'b1;
                    end else if (ones_cnt_q == CNT_W'(6)) begin
                        if (one_c) go_err = 1'b1;
                        else       ones_cnt_d = CNT_W'(0);
                    end else begin
                        bit_valid_d = 1'b1;
                        bit_out_d   = one_c;
                        ones_cnt_d  = one_c ? ones_cnt_q + CNT_W'(1) : CNT_W'(0);
                    end
                end
            end
            ST_EOP: begin
                if (sample_c) begin
                    if ((line_prev_q == LINE_SE0) && (eop_cnt_q < EOP_W'(2))) begin
                        eop_cnt_d = eop_cnt_q + EOP_W'(1);
                    end else if ((line_prev_q == LINE_J) && (eop_cnt_q != EOP_W'(0))) begin
                        state_d     = ST_COMPLETE;
                        done_d      = 1'b1;
                        rx_active_d = 1'b0;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            ST_ERROR: begin
                // Leave only after seven consecutive idle (J) samples.
                if (sample_c) begin
                    if (line_prev_q != LINE_J) begin
                        j_cnt_d = CNT_W'(0);
                    end else if (j_cnt_q == CNT_W'(6)) begin
                        j_cnt_d = CNT_W'(0);
                        state_d = ST_IDLE;
                    end else begin
                        j_cnt_d = j_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_err) begin
            state_d     = ST_ERROR;
            error_d     = 1'b1;
            rx_active_d = 1'b0;
            j_cnt_d     = CNT_W'(0);
        end
    end

    always_ff @(posedge clk48) begin
        if (!reset) begin
            line_q      <= LINE_J;
            line_prev_q <= LINE_J;
            samp_prev_q <= LINE_J;
            phase_q     <= PHASE_W'(0);
            state_q     <= ST_IDLE;
            sync_cnt_q  <= CNT_W'(0);
            ones_cnt_q  <= CNT_W'(0);
            j_cnt_q     <= CNT_W'(0);
            eop_cnt_q   <= EOP_W'(0);
            rx_active_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            line_q      <= line_in;
            line_prev_q <= line_q;
            samp_prev_q <= samp_prev_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            j_cnt_q     <= j_cnt_d;
            eop_cnt_q   <= eop_cnt_d;
            rx_active_q <= rx_active_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rx_active = rx_active_q;
    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule
